// File: rtl/shift_reg_sequencer_if.sv
// Command/data bundle between a controller and the shift-register sequencer.
// The sequencer side (slave) receives the command and returns register state and status.
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             start;
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output start, op, count, din, sin,
        input  q, sout, busy, done
    );

    modport slave (
        input  start, op, count, din, sin,
        output q, sout, busy, done
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Multi-step shift register: accepts load/shift/rotate commands in IDLE and
// executes them one step per clock through a LOAD/SHIFT/DONE Moore sequence.
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shift_reg_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // One shift/rotate step; result is {bit_out, new_register}.
    function automatic logic [WIDTH:0] step_f(
        input logic [1:0]       op_i,
        input logic [WIDTH-1:0] q_i,
        input logic             sin_i
    );
        logic [WIDTH:0] res;
        case (op_i)
            OP_SHR:  res = {q_i[0], sin_i, q_i[WIDTH-1:1]};
            OP_SHL:  res = {q_i[WIDTH-1], q_i[WIDTH-2:0], sin_i};
            OP_ROR:  res = {q_i[0], q_i[0], q_i[WIDTH-1:1]};
            default: res = {1'b0, q_i};
        endcase
        return res;
    endfunction

    // Next-state, datapath and status decode.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    din_d = bus.din;
                    if (bus.op == OP_LOAD) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_LOAD;
                    end else if (bus.count == {CNT_W{1'b0}}) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = bus.count;
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                q_d     = din_q;
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                {sout_d, q_d} = step_f(op_q, q_q, bus.sin);
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status flags are registered copies of the next-state decode.
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= {WIDTH{1'b0}};
            sout_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 2'b00;
            din_q   <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed, table-driven bench for shift_reg_sequencer: one table row per clock
// edge, plus hand-written sequences for long rotates and mid-cycle reset.
module tb_shift_reg_sequencer;

    logic clk;
    logic rst_n;

    shift_reg_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

    shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic       start;
        logic [1:0] op;
        logic [2:0] count;
        logic [3:0] din;
        logic       sin;
        logic [3:0] eq;
        logic       es;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t tbl [0:63];
    int   n_vec;
    int   compared;
    int   mismatched;

    function automatic vec_t mk(
        input logic r, input logic s, input logic [1:0] o, input logic [2:0] c,
        input logic [3:0] d, input logic si,
        input logic [3:0] eq, input logic es, input logic eb, input logic ed
    );
        vec_t v;
        v.rst_n = r; v.start = s; v.op = o; v.count = c; v.din = d; v.sin = si;
        v.eq = eq; v.es = es; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s row %0d: got %b want %b", name, row, act, exp);
        end
    endtask

    task automatic add(input vec_t v);
        tbl[n_vec] = v;
        n_vec++;
    endtask

    initial begin
        int busy_cycles;
        logic got_done;

        compared   = 0;
        mismatched = 0;
        n_vec      = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.count  = 3'd0;
        bus.din    = 4'b0000;
        bus.sin    = 1'b0;

        //      rst start op     cnt   din      sin   q        sout  busy  done
        add(mk(1'b0, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0));
        add(mk(1'b0, 1'b1, 2'b00, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0));
        // Load 1011
        add(mk(1'b1, 1'b1, 2'b00, 3'd0, 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b1));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0));
        // Shift right by 2, sin=0
        add(mk(1'b1, 1'b1, 2'b01, 3'd2, 4'b0000, 1'b0, 4'b1011, 1'b0, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0101, 1'b1, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0));
        // Load 1001, rotate right by 4
        add(mk(1'b1, 1'b1, 2'b00, 3'd0, 4'b1001, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b1));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0));
        add(mk(1'b1, 1'b1, 2'b11, 3'd4, 4'b0000, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1100, 1'b1, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0011, 1'b0, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b1));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0));
        // Load 0000, shift left by 5 with sin=1; start and new inputs mid-op ignored
        add(mk(1'b1, 1'b1, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1001, 1'b1, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0));
        add(mk(1'b1, 1'b1, 2'b10, 3'd5, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0));
        add(mk(1'b1, 1'b1, 2'b00, 3'd1, 4'b1010, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0));
        add(mk(1'b1, 1'b1, 2'b01, 3'd0, 4'b1010, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0));
        add(mk(1'b1, 1'b1, 2'b00, 3'd0, 4'b0101, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1));
        add(mk(1'b1, 1'b1, 2'b00, 3'd0, 4'b0101, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0));
        // Load 0110, shift right with count=0
        add(mk(1'b1, 1'b1, 2'b00, 3'd0, 4'b0110, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b1));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0));
        add(mk(1'b1, 1'b1, 2'b01, 3'd0, 4'b0000, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b1));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0));
        // Shift left by 7, reset after the first step aborts it
        add(mk(1'b1, 1'b1, 2'b10, 3'd7, 4'b0000, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b1, 4'b1101, 1'b0, 1'b1, 1'b0));
        add(mk(1'b0, 1'b1, 2'b00, 3'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0));
        add(mk(1'b1, 1'b1, 2'b00, 3'd0, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b1));
        add(mk(1'b1, 1'b0, 2'b00, 3'd0, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < n_vec; i++) begin
            rst_n     = tbl[i].rst_n;
            bus.start = tbl[i].start;
            bus.op    = tbl[i].op;
            bus.count = tbl[i].count;
            bus.din   = tbl[i].din;
            bus.sin   = tbl[i].sin;
            @(posedge clk);
            #1;
            chk("q",    i, {4'b0000, bus.q},    {4'b0000, tbl[i].eq});
            chk("sout", i, {7'b0, bus.sout},    {7'b0, tbl[i].es});
            chk("busy", i, {7'b0, bus.busy},    {7'b0, tbl[i].eb});
            chk("done", i, {7'b0, bus.done},    {7'b0, tbl[i].ed});
        end

        // Rotate 1010 right by 7: net rotate by 3 gives 0101, last bit out 0.
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.count = 3'd7;
        bus.sin   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int k = 0; k < 20 && !got_done; k++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                got_done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("ror7_done",  100, {7'b0, got_done}, 8'd1);
        chk("ror7_busy",  100, 8'(busy_cycles),  8'd7);
        chk("ror7_q",     100, {4'b0000, bus.q}, 8'b0000_0101);
        chk("ror7_sout",  100, {7'b0, bus.sout}, 8'd0);

        // Reset asserted between edges must not act until the next edge.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst_mid_q",  101, {4'b0000, bus.q}, 8'b0000_0101);
        @(posedge clk);
        #1;
        chk("rst_edge_q", 101, {4'b0000, bus.q}, 8'b0000_0000);
        chk("rst_edge_d", 101, {7'b0, bus.done}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width in bits.
REQ-002 SHALL have parameter CNT_W, default 3, width of the shift-count field.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  command request, sampled only in IDLE.
REQ-006 SHALL have port op  input  2  command: 00 parallel load, 01 shift right, 10 shift left, 11 rotate right.
REQ-007 SHALL have port count  input  CNT_W  number of shift/rotate steps (0..7); ignored for load.
REQ-008 SHALL have port din  input  WIDTH  parallel load data.
REQ-009 SHALL have port sin  input  1  serial fill bit, sampled on every shift step.
REQ-010 SHALL have port q  output  WIDTH  register contents, registered.
REQ-011 SHALL have port sout  output  1  last bit shifted or rotated out, registered.
REQ-012 SHALL have port busy  output  1  high while in LOAD or SHIFT.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse, high only in DONE.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, LOAD, SHIFT, DONE; busy and done decode from state only.
REQ-015 In IDLE with start=1 at an edge, SHALL latch op, count, din; next state LOAD if op=00, DONE if op!=00 and count=0, else SHIFT.
REQ-016 In IDLE with start=0, SHALL remain in IDLE with q and sout held.
REQ-017 LOAD SHALL last exactly one cycle: next edge q<=latched din, sout unchanged, next state DONE.
REQ-018 SHIFT SHALL perform exactly one step per edge using an internal down-counter loaded with count; after the count-th step next state is DONE.
REQ-019 Shift right step: q<={sin, q[WIDTH-1:1]}, sout<=q[0].
REQ-020 Shift left step: q<={q[WIDTH-2:0], sin}, sout<=q[WIDTH-1].
REQ-021 Rotate right step: q<={q[0], q[WIDTH-1:1]}, sout<=q[0]; sin ignored.
REQ-022 count greater than WIDTH SHALL be honored in full (no clamping); register fully refilled from sin for shifts.
REQ-023 count=0 with op!=00 SHALL change neither q nor sout; busy never asserts; done asserts the cycle after the start edge.
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-025 start asserted in LOAD, SHIFT or DONE SHALL be ignored and not queued; a new command is accepted earliest on the edge after DONE.
REQ-026 Latency: load completes count=1 edge after acceptance; shift completes count edges after acceptance; done follows one cycle later.
REQ-027 din, op, count changes after acceptance SHALL not affect the command in progress.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force state IDLE, q=0, sout=0, busy=0, done=0, counter=0.
REQ-029 Reset SHALL take priority over start and over any in-progress command; an aborted command never produces done.
REQ-030 Reset is synchronous only; rst_n falling between edges SHALL not change outputs until the next edge.

Verification
REQ-031 Reset, then start op=00 din=1011 -> q=1011 after 1 edge, busy high 1 cycle, done pulse 1 cycle, sout=0.
REQ-032 From q=1011, op=01 count=2 sin=0 -> q=0101 then 0010, sout=1, busy high 2 cycles, then done pulse.
REQ-033 From q=1001, op=11 count=4 -> q=1100,0110,0011,1001; busy high 4 cycles; final sout=1.
REQ-034 From q=0000, op=10 count=5 sin=1 -> q=1111 after 5 edges; start pulsed mid-operation ignored (busy exactly 5 cycles).
REQ-035 From q=0110, op=01 count=0 -> q=0110 unchanged, busy never high, done high the cycle after acceptance.
REQ-036 rst_n=0 during SHIFT (op=10 count=7) -> next edge q=0000, busy=0, no done; start after release accepted normally.
